wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of the data path and of every register.
REQ-002 Parameter: ADDRESS_WIDTH, default 32, width of the PC+4 value.
REQ-003 Port: clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: w_aluresult  in  DATA_WIDTH  writeback-stage ALU result.
REQ-006 Port: w_readdata  in  DATA_WIDTH  writeback-stage load data.
REQ-007 Port: w_pcplus4  in  ADDRESS_WIDTH  writeback-stage PC+4, for JAL/JALR link.
REQ-008 Port: w_rd  in  5  destination register address.
REQ-009 Port: w_regwrite  in  1  write enable.
REQ-010 Port: w_resultsrc  in  2  result select.
REQ-011 Port: rs1_addr, rs2_addr  in  5 each  decode-stage read addresses.
REQ-012 Port: rs1_data, rs2_data  out  DATA_WIDTH each  read data.
REQ-013 Port: w_result  out  DATA_WIDTH  selected writeback value, for forwarding.
REQ-014 Port: a0  out  DATA_WIDTH  continuous view of register x10.
REQ-015 Port: wb_count  out  32  count of committed register writes.

Function
REQ-016 w_result SHALL be combinational: resultsrc 00 -> w_aluresult, 01 -> w_readdata, 10 -> w_pcplus4 (zero-extended or truncated to DATA_WIDTH), 11 -> w_aluresult.
REQ-017 Storage SHALL be 32 registers x0..x31 of DATA_WIDTH bits each.
REQ-018 On a rising clk with w_regwrite=1 and w_rd!=0, register[w_rd] SHALL take w_result.
REQ-019 Writes with w_rd=0 SHALL be discarded; x0 SHALL always read 0.
REQ-020 rs1_data and rs2_data SHALL be combinational reads of the addressed registers; there is no read latency.
REQ-021 a0 SHALL always equal register x10, including the value after a write, from the cycle following that write.
REQ-022 wb_count SHALL increment by 1 on each committed write (REQ-018) and wrap from 0xFFFFFFFF to 0.
REQ-023 Writes with w_regwrite=1 and w_rd=0 SHALL NOT increment wb_count.
REQ-024 If both read ports address the same register, both SHALL return identical data.

Reset
REQ-025 When rst is asserted, all 32 registers and wb_count SHALL clear to 0 immediately, without waiting for clk.
REQ-026 While rst is high, writes SHALL be blocked and rs1_data, rs2_data and a0 SHALL read 0.
REQ-027 A write presented on the same edge on which rst deasserts SHALL NOT be committed.
REQ-028 Write processing SHALL resume from the first rising clk that follows rst deassertion.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN SHALL select the internal write-through bypass.
REQ-030 With the macro defined: if w_regwrite=1, w_rd!=0, rst=0 and rsN_addr==w_rd, rsN_data SHALL return w_result in the same cycle.
REQ-031 Without the macro: a read of the register being written SHALL return the old value until the edge completes, and the hazard unit is responsible for the forwarding.

Verification
REQ-032 Scenario, reset: assert rst mid-cycle after writing x5=0x1234 -> x5, a0 and wb_count read 0 before the next clk edge.
REQ-033 Scenario, result mux: regwrite=1, rd=7, resultsrc=00/01/10 with alu=0xA, readdata=0xB, pcplus4=0xC on three edges -> x7 reads 0xA, then 0xB, then 0xC; wb_count=3.
REQ-034 Scenario, x0 write: regwrite=1, rd=0, alu=0xDEADBEEF -> rs1_addr=0 reads 0 and wb_count is unchanged.
REQ-035 Scenario, bypass: rd=10 write of 0x55 with rs1_addr=10 in the same cycle -> rs1_data=0x55 in that cycle with REGFILE_BYPASS_EN, old value without it; a0=0x55 after the edge in both builds.
REQ-036 Scenario, counter wrap: force wb_count to 0xFFFFFFFF, then one write to x1 -> wb_count=0.
REQ-037 Scenario, regwrite low: regwrite=0, rd=3, alu=0x99 -> x3 is unchanged and wb_count is unchanged.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: 32 x DATA_WIDTH register file with writeback result mux.
//
// Ports:
//   clk, rst       - single clock; asynchronous active-high reset
//   w_aluresult    - writeback-stage ALU result
//   w_readdata     - writeback-stage load data
//   w_pcplus4      - writeback-stage PC+4 (link value for JAL/JALR)
//   w_rd           - destination register address
//   w_regwrite     - write enable
//   w_resultsrc    - result select: 00 ALU, 01 load, 10 PC+4, 11 ALU
//   rs1_addr/_data - read port 1 (combinational)
//   rs2_addr/_data - read port 2 (combinational)
//   w_result       - selected writeback value, for forwarding
//   a0             - continuous view of register x10
//   wb_count       - count of committed register writes (wraps)
//
// Configuration macro: REGFILE_BYPASS_EN
//   defined   - a read of the register being written returns w_result
//   undefined - reads return the stored value; forwarding is external
module wb_regfile #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    w_aluresult,
    input  logic [DATA_WIDTH-1:0]    w_readdata,
    input  logic [ADDRESS_WIDTH-1:0] w_pcplus4,
    input  logic [4:0]               w_rd,
    input  logic                     w_regwrite,
    input  logic [1:0]               w_resultsrc,
    input  logic [4:0]               rs1_addr,
    input  logic [4:0]               rs2_addr,
    output logic [DATA_WIDTH-1:0]    rs1_data,
    output logic [DATA_WIDTH-1:0]    rs2_data,
    output logic [DATA_WIDTH-1:0]    w_result,
    output logic [DATA_WIDTH-1:0]    a0,
    output logic [31:0]              wb_count
);

    logic [DATA_WIDTH-1:0] regs_q [32];
    logic [31:0]           wb_count_q;
    logic [31:0]           wb_count_d;
    logic                  write_en;

    always_comb begin
        w_result = w_aluresult;
        case (w_resultsrc)
            2'b01:   w_result = w_readdata;
            2'b10:   w_result = DATA_WIDTH'(w_pcplus4);
            default: w_result = w_aluresult;
        endcase
    end

    assign write_en   = w_regwrite && (w_rd != 5'd0);
    assign wb_count_d = wb_count_q + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            wb_count_q <= '0;
        end else if (write_en) begin
            regs_q[w_rd] <= w_result;
            wb_count_q   <= wb_count_d;
        end
    end

    // Read ports: x0 and reset force zero; optional write-through bypass.
    always_comb begin
        rs1_data = regs_q[rs1_addr];
        if (rst || rs1_addr == 5'd0) begin
            rs1_data = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (write_en && rs1_addr == w_rd) begin
            rs1_data = w_result;
        end
`endif
    end

    always_comb begin
        rs2_data = regs_q[rs2_addr];
        if (rst || rs2_addr == 5'd0) begin
            rs2_data = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (write_en && rs2_addr == w_rd) begin
            rs2_data = w_result;
        end
`endif
    end

    assign a0       = rst ? '0 : regs_q[10];
    assign wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: randomized + directed bench for wb_regfile with an
// array-based reference model checked on every falling clock edge.
module tb_wb_regfile;

    localparam int DW = 32;
    localparam int AW = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] w_aluresult = '0;
    logic [DW-1:0] w_readdata  = '0;
    logic [AW-1:0] w_pcplus4   = '0;
    logic [4:0]    w_rd        = '0;
    logic          w_regwrite  = 1'b0;
    logic [1:0]    w_resultsrc = '0;
    logic [4:0]    rs1_addr    = '0;
    logic [4:0]    rs2_addr    = '0;
    logic [DW-1:0] rs1_data, rs2_data, w_result, a0;
    logic [31:0]   wb_count;

    wb_regfile #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .w_aluresult(w_aluresult),
        .w_readdata (w_readdata),
        .w_pcplus4  (w_pcplus4),
        .w_rd       (w_rd),
        .w_regwrite (w_regwrite),
        .w_resultsrc(w_resultsrc),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .w_result   (w_result),
        .a0         (a0),
        .wb_count   (wb_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [DW-1:0] mregs [32];
    logic [31:0]   mcount;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [DW-1:0] exp_result();
        case (w_resultsrc)
            2'b01:   return w_readdata;
            2'b10:   return w_pcplus4[DW-1:0];
            default: return w_aluresult;
        endcase
    endfunction

    function automatic logic [DW-1:0] exp_read(input logic [4:0] addr);
        if (rst || addr == 5'd0) return '0;
        if (BYP && w_regwrite && w_rd != 5'd0 && addr == w_rd) return exp_result();
        return mregs[addr];
    endfunction

    // Reference model: reset clears everything at once; each clock with a
    // nonzero destination and enable stores the selected value and counts it.
    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        mcount = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < 32; i++) mregs[i] = '0;
                mcount = '0;
            end else if (w_regwrite && w_rd != 5'd0) begin
                mregs[w_rd] = exp_result();
                mcount      = mcount + 32'd1;
            end
        end
    end

    // Continuous compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("w_result", w_result, exp_result());
            check("rs1_data", rs1_data, exp_read(rs1_addr));
            check("rs2_data", rs2_data, exp_read(rs2_addr));
            check("a0",       a0,       rst ? '0 : mregs[10]);
            check("wb_count", wb_count, mcount);
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        edge1();
        edge1();
        rs1_addr = 5'd10;
        rs2_addr = 5'd31;
        #1;
        check("rst_rs1", rs1_data, 32'h0);
        check("rst_rs2", rs2_data, 32'h0);
        check("rst_cnt", wb_count, 32'h0);
        rst = 1'b0;
        edge1();
        check("idle_cnt", wb_count, 32'h0);

        // Result mux into x7
        w_regwrite = 1'b1; w_rd = 5'd7; w_resultsrc = 2'b00;
        w_aluresult = 32'hA; w_readdata = 32'hB; w_pcplus4 = 32'hC;
        rs1_addr = 5'd7;
        edge1();
        check("mux_alu", rs1_data, 32'hA);
        w_resultsrc = 2'b01;
        edge1();
        check("mux_load", rs1_data, 32'hB);
        w_resultsrc = 2'b10;
        edge1();
        check("mux_pc", rs1_data, 32'hC);
        w_regwrite = 1'b0;
        #1;
        check("mux_x7", rs1_data, 32'hC);
        check("mux_cnt", wb_count, 32'd3);

        // x0 write discarded
        w_regwrite = 1'b1; w_rd = 5'd0; w_resultsrc = 2'b00; w_aluresult = 32'hDEADBEEF;
        rs1_addr = 5'd0;
        edge1();
        w_regwrite = 1'b0;
        #1;
        check("x0_read", rs1_data, 32'h0);
        check("x0_cnt", wb_count, 32'd3);

        // regwrite low
        w_rd = 5'd3; w_aluresult = 32'h99; rs2_addr = 5'd3;
        edge1();
        check("nowe_x3", rs2_data, 32'h0);
        check("nowe_cnt", wb_count, 32'd3);

        // Same-cycle read of x10 while writing it
        w_regwrite = 1'b1; w_rd = 5'd10; w_aluresult = 32'h55; rs1_addr = 5'd10;
        #1;
        check("byp_same", rs1_data, BYP ? 32'h55 : 32'h0);
        edge1();
        w_regwrite = 1'b0;
        #1;
        check("byp_a0", a0, 32'h55);
        check("byp_cnt", wb_count, 32'd4);

        // Mid-cycle asynchronous reset after writing x5
        w_regwrite = 1'b1; w_rd = 5'd5; w_aluresult = 32'h1234;
        edge1();
        w_regwrite = 1'b0; rs1_addr = 5'd5;
        #1;
        check("pre_x5", rs1_data, 32'h1234);
        rst = 1'b1;
        #1;
        check("arst_x5", rs1_data, 32'h0);
        check("arst_a0", a0, 32'h0);
        check("arst_cnt", wb_count, 32'h0);

        // Write presented on the edge where reset is still high is dropped
        w_regwrite = 1'b1; w_rd = 5'd6; w_aluresult = 32'h66; rs2_addr = 5'd6;
        edge1();
        rst = 1'b0;
        w_regwrite = 1'b0;
        #1;
        check("rstedge_x6", rs2_data, 32'h0);
        check("rstedge_cnt", wb_count, 32'h0);
        w_regwrite = 1'b1;
        edge1();
        w_regwrite = 1'b0;
        #1;
        check("resume_x6", rs2_data, 32'h66);
        check("resume_cnt", wb_count, 32'd1);

        // Counter wrap
        force dut.wb_count_q = 32'hFFFFFFFF;
        #1;
        release dut.wb_count_q;
        mcount = 32'hFFFFFFFF;
        #1;
        check("force_cnt", wb_count, 32'hFFFFFFFF);
        w_regwrite = 1'b1; w_rd = 5'd1; w_aluresult = 32'h1;
        edge1();
        w_regwrite = 1'b0;
        #1;
        check("wrap_cnt", wb_count, 32'h0);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            edge1();
            rst         = ($urandom_range(0, 59) == 0);
            w_regwrite  = $urandom_range(0, 3) != 0;
            w_rd        = 5'($urandom_range(0, 31));
            w_resultsrc = 2'($urandom_range(0, 3));
            w_aluresult = $urandom;
            w_readdata  = $urandom;
            w_pcplus4   = $urandom;
            rs1_addr    = ($urandom_range(0, 3) == 0) ? w_rd : 5'($urandom_range(0, 31));
            rs2_addr    = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom_range(0, 31));
        end
        rst = 1'b0;
        w_regwrite = 1'b0;
        edge1();
        edge1();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
